// File: rtl/ann_pkg.sv
// Shared types and helpers for the patch-ANN search sequencer.
//   main_state_t  : top-level sequencer states
//   search_mode_t : frame search mode latched at frame start
//   width_of      : counter width able to hold 0..n-1 (never zero bits)
package ann_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXACT_SWEEP,
    ST_SEARCH_LEAF,
    ST_DRAIN,
    ST_HANDOFF
  } main_state_t;

  typedef enum logic {
    MODE_TREE  = 1'b0,
    MODE_EXACT = 1'b1
  } search_mode_t;

  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ann_wrap_counter.sv
// Up-counter that wraps to zero when it advances from its limit value.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : advance one step this cycle
//   clr       : force to zero (wins over en)
//   limit     : last value before wrapping
//   count     : current value
//   at_limit  : count equals limit
module ann_wrap_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  assign at_limit = (count == limit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_limit ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/main_fsm_multirow.sv
// Frame-level search sequencer for patch ANN. Walks every query of every
// row: row 0 (or every row in exact mode) sweeps all leaves on port 0, the
// remaining rows read NUM_CANDIDATES candidate leaves on port 1. Each query
// then drains the L2 pipeline and hands its result to stage 0.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   fsm_start, mode_exact_all: frame start (Idle only) and mode select
//   cand_valid/idx/ready     : candidate leaf handshake
//   leaf_mem_*0              : port 0 sweep reads (active-low csb/web)
//   leaf_mem_*1              : port 1 candidate reads (active-low csb)
//   k0_query_valid           : a leaf read is issued this cycle
//   rm_restart               : running-min restart pulse
//   s0_valid_in, s0_ready    : result handoff to stage 0
//   query_idx, row_idx       : current query position
//   busy, done               : frame in progress / frame finished pulse
//
// state          | meaning
// ST_IDLE        | waiting for fsm_start
// ST_EXACT_SWEEP | reading leaves 0..NUM_LEAVES-1 on port 0
// ST_SEARCH_LEAF | accepting candidate indices, reading them on port 1
// ST_DRAIN       | no reads; letting the L2 pipeline finish
// ST_HANDOFF     | presenting the query result until stage 0 accepts
module main_fsm_multirow
  import ann_pkg::*;
#(
  parameter int NUM_LEAVES      = 64,
  parameter int ADDR_WIDTH      = $clog2(NUM_LEAVES),
  parameter int QUERIES_PER_ROW = 26,
  parameter int NUM_ROWS        = 26,
  parameter int NUM_CANDIDATES  = 2,
  parameter int L2_LATENCY      = 6,
  parameter int DRAIN_CYCLES    = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  fsm_start,
  input  logic                                  mode_exact_all,
  input  logic                                  cand_valid,
  input  logic [ADDR_WIDTH-1:0]                 cand_idx,
  output logic                                  cand_ready,
  output logic                                  leaf_mem_csb0,
  output logic                                  leaf_mem_web0,
  output logic [ADDR_WIDTH-1:0]                 leaf_mem_addr0,
  output logic                                  leaf_mem_csb1,
  output logic [ADDR_WIDTH-1:0]                 leaf_mem_addr1,
  output logic                                  k0_query_valid,
  output logic                                  rm_restart,
  output logic                                  s0_valid_in,
  input  logic                                  s0_ready,
  output logic [width_of(QUERIES_PER_ROW)-1:0]  query_idx,
  output logic [width_of(NUM_ROWS)-1:0]         row_idx,
  output logic                                  busy,
  output logic                                  done
);

  localparam int QW      = width_of(QUERIES_PER_ROW);
  localparam int RW      = width_of(NUM_ROWS);
  localparam int CW      = width_of(NUM_CANDIDATES);
  localparam int DW      = width_of(DRAIN_CYCLES);
  // rel saturates here so long candidate bubbles cannot wrap it back onto
  // L2_LATENCY and fire a second restart.
  localparam int REL_MAX = NUM_LEAVES + DRAIN_CYCLES + L2_LATENCY;
  localparam int REL_W   = $clog2(REL_MAX + 1);

  main_state_t   state;
  search_mode_t  mode_q;
  logic [REL_W-1:0] rel_q;
  logic [REL_W-1:0] rel_now;
  logic          rel_run;
  logic          done_q;

  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [DW-1:0]         drain_cnt;
  logic [CW-1:0]         cand_cnt;
  logic [QW-1:0]         q_cnt;
  logic [RW-1:0]         r_cnt;
  logic sweep_at_limit, drain_at_limit, cand_at_limit, q_at_limit, r_at_limit;

  logic in_exact, in_handoff, accept, read_now, start_go, handoff_acc;
  logic last_query, next_exact;
  logic unused_cnt_bits;

  assign in_exact    = (state == ST_EXACT_SWEEP);
  assign in_handoff  = (state == ST_HANDOFF);
  assign cand_ready  = (state == ST_SEARCH_LEAF);
  assign accept      = cand_valid & cand_ready;
  assign read_now    = in_exact | accept;
  // done_q marks the cycle right after the final handoff; a start there is dropped.
  assign start_go    = (state == ST_IDLE) & fsm_start & ~done_q;
  assign handoff_acc = in_handoff & s0_ready;
  assign last_query  = q_at_limit & r_at_limit;
  // The next query stays in row 0 unless this one closes the row.
  assign next_exact  = (mode_q == MODE_EXACT) | (~q_at_limit & (r_cnt == '0));

  assign unused_cnt_bits = ^{drain_cnt, cand_cnt};

  ann_wrap_counter #(.WIDTH(ADDR_WIDTH)) u_sweep_cnt (
    .clk(clk), .rst(rst), .en(in_exact), .clr(start_go),
    .limit(ADDR_WIDTH'(NUM_LEAVES - 1)), .count(sweep_cnt), .at_limit(sweep_at_limit)
  );

  ann_wrap_counter #(.WIDTH(DW)) u_drain_cnt (
    .clk(clk), .rst(rst), .en(state == ST_DRAIN), .clr(start_go),
    .limit(DW'(DRAIN_CYCLES - 1)), .count(drain_cnt), .at_limit(drain_at_limit)
  );

  ann_wrap_counter #(.WIDTH(CW)) u_cand_cnt (
    .clk(clk), .rst(rst), .en(accept), .clr(start_go),
    .limit(CW'(NUM_CANDIDATES - 1)), .count(cand_cnt), .at_limit(cand_at_limit)
  );

  ann_wrap_counter #(.WIDTH(QW)) u_query_cnt (
    .clk(clk), .rst(rst), .en(handoff_acc), .clr(start_go),
    .limit(QW'(QUERIES_PER_ROW - 1)), .count(q_cnt), .at_limit(q_at_limit)
  );

  ann_wrap_counter #(.WIDTH(RW)) u_row_cnt (
    .clk(clk), .rst(rst), .en(handoff_acc & q_at_limit), .clr(start_go),
    .limit(RW'(NUM_ROWS - 1)), .count(r_cnt), .at_limit(r_at_limit)
  );

  // rel reads as 0 on the first read of a query, then follows the register.
  assign rel_now = rel_run ? rel_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_TREE;
      rel_q   <= '0;
      rel_run <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (read_now || rel_run) begin
        rel_q   <= (rel_now == REL_W'(REL_MAX)) ? rel_now : rel_now + REL_W'(1);
        rel_run <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start_go) begin
            state  <= ST_EXACT_SWEEP;
            mode_q <= mode_exact_all ? MODE_EXACT : MODE_TREE;
          end
        end
        ST_EXACT_SWEEP: begin
          if (sweep_at_limit) state <= ST_DRAIN;
        end
        ST_SEARCH_LEAF: begin
          if (accept && cand_at_limit) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (drain_at_limit) begin
            state   <= ST_HANDOFF;
            rel_run <= 1'b0;
          end
        end
        ST_HANDOFF: begin
          if (s0_ready) begin
            if (last_query) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end else if (next_exact) begin
              state <= ST_EXACT_SWEEP;
            end else begin
              state <= ST_SEARCH_LEAF;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign leaf_mem_csb0  = ~in_exact;
  assign leaf_mem_web0  = 1'b1;
  assign leaf_mem_addr0 = in_exact ? sweep_cnt : '0;
  assign leaf_mem_csb1  = ~accept;
  assign leaf_mem_addr1 = accept ? cand_idx : '0;
  assign k0_query_valid = read_now;
  assign rm_restart     = (read_now | rel_run) & (rel_now == REL_W'(L2_LATENCY));
  assign s0_valid_in    = in_handoff;
  assign query_idx      = q_cnt;
  assign row_idx        = r_cnt;
  assign busy           = (state != ST_IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_main_fsm_multirow.sv
// Directed bench for main_fsm_multirow: 8 leaves, 2 rows of 2 queries,
// 2 candidates, L2 latency 6, drain 6.
module tb_main_fsm_multirow;

  localparam int NL = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          fsm_start;
  logic          mode_exact_all;
  logic          cand_valid;
  logic [AW-1:0] cand_idx;
  logic          cand_ready;
  logic          leaf_mem_csb0;
  logic          leaf_mem_web0;
  logic [AW-1:0] leaf_mem_addr0;
  logic          leaf_mem_csb1;
  logic [AW-1:0] leaf_mem_addr1;
  logic          k0_query_valid;
  logic          rm_restart;
  logic          s0_valid_in;
  logic          s0_ready;
  logic [0:0]    query_idx;
  logic [0:0]    row_idx;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  main_fsm_multirow #(
    .NUM_LEAVES(NL), .ADDR_WIDTH(AW), .QUERIES_PER_ROW(2), .NUM_ROWS(2),
    .NUM_CANDIDATES(2), .L2_LATENCY(6), .DRAIN_CYCLES(6)
  ) dut (
    .clk(clk), .rst(rst), .fsm_start(fsm_start), .mode_exact_all(mode_exact_all),
    .cand_valid(cand_valid), .cand_idx(cand_idx), .cand_ready(cand_ready),
    .leaf_mem_csb0(leaf_mem_csb0), .leaf_mem_web0(leaf_mem_web0),
    .leaf_mem_addr0(leaf_mem_addr0), .leaf_mem_csb1(leaf_mem_csb1),
    .leaf_mem_addr1(leaf_mem_addr1), .k0_query_valid(k0_query_valid),
    .rm_restart(rm_restart), .s0_valid_in(s0_valid_in), .s0_ready(s0_ready),
    .query_idx(query_idx), .row_idx(row_idx), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the edge that started the sweep.
  task automatic exact_query(input int q, input int r, input int hold);
    for (int i = 0; i < NL; i++) begin
      chk("sweep_addr0", leaf_mem_addr0, i);
      chk("sweep_csb0", leaf_mem_csb0, 0);
      chk("sweep_k0", k0_query_valid, 1);
      chk("sweep_rm", rm_restart, (i == 6));
      chk("sweep_cand_ready", cand_ready, 0);
      chk("sweep_csb1", leaf_mem_csb1, 1);
      chk("sweep_query", query_idx, q);
      chk("sweep_row", row_idx, r);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      chk("drain_csb0", leaf_mem_csb0, 1);
      chk("drain_k0", k0_query_valid, 0);
      chk("drain_rm", rm_restart, 0);
      chk("drain_s0v", s0_valid_in, 0);
      tick();
    end
    for (int h = 0; h < hold; h++) begin
      chk("hold_s0v", s0_valid_in, 1);
      chk("hold_query", query_idx, q);
      chk("hold_row", row_idx, r);
      tick();
    end
    s0_ready = 1'b1;
    #1;
    chk("handoff_s0v", s0_valid_in, 1);
    chk("handoff_query", query_idx, q);
    chk("handoff_row", row_idx, r);
    tick();
    s0_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; fsm_start = 1'b0; mode_exact_all = 1'b0;
    cand_valid = 1'b0; cand_idx = '0; s0_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_csb0", leaf_mem_csb0, 1);
    chk("rst_csb1", leaf_mem_csb1, 1);
    chk("rst_web0", leaf_mem_web0, 1);
    chk("rst_addr0", leaf_mem_addr0, 0);
    chk("rst_addr1", leaf_mem_addr1, 0);
    chk("rst_k0", k0_query_valid, 0);
    chk("rst_rm", rm_restart, 0);
    chk("rst_s0v", s0_valid_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_query", query_idx, 0);
    chk("rst_row", row_idx, 0);
    chk("rst_cand_ready", cand_ready, 0);

    // Start, then reset in the middle of the sweep.
    fsm_start = 1'b1;
    tick();
    fsm_start = 1'b0;
    chk("pre_rst_addr0", leaf_mem_addr0, 0);
    chk("pre_rst_busy", busy, 1);
    tick();
    tick();
    chk("pre_rst_addr2", leaf_mem_addr0, 2);
    rst = 1'b1;
    tick();
    chk("mid_rst_csb0", leaf_mem_csb0, 1);
    chk("mid_rst_k0", k0_query_valid, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_csb0", leaf_mem_csb0, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_addr0", leaf_mem_addr0, 0);
    chk("post_rst_row", row_idx, 0);

    // Frame in tree mode: row 0 swept, row 1 searched.
    fsm_start = 1'b1;
    tick();
    fsm_start = 1'b0;
    exact_query(0, 0, 3);
    exact_query(1, 0, 0);

    // Row 1 query 0: idle cycle, cand 5, bubble, cand 6.
    chk("r1q0_wait_ready", cand_ready, 1);
    chk("r1q0_wait_k0", k0_query_valid, 0);
    chk("r1q0_wait_csb0", leaf_mem_csb0, 1);
    chk("r1q0_wait_rm", rm_restart, 0);
    chk("r1q0_row", row_idx, 1);
    chk("r1q0_query", query_idx, 0);
    tick();
    cand_valid = 1'b1; cand_idx = 3'd5;
    #1;
    chk("r1q0_c5_csb1", leaf_mem_csb1, 0);
    chk("r1q0_c5_addr1", leaf_mem_addr1, 5);
    chk("r1q0_c5_k0", k0_query_valid, 1);
    chk("r1q0_c5_csb0", leaf_mem_csb0, 1);
    tick();
    cand_valid = 1'b0;
    #1;
    chk("r1q0_bub_csb1", leaf_mem_csb1, 1);
    chk("r1q0_bub_k0", k0_query_valid, 0);
    chk("r1q0_bub_rm", rm_restart, 0);
    tick();
    cand_valid = 1'b1; cand_idx = 3'd6;
    #1;
    chk("r1q0_c6_csb1", leaf_mem_csb1, 0);
    chk("r1q0_c6_addr1", leaf_mem_addr1, 6);
    chk("r1q0_c6_k0", k0_query_valid, 1);
    tick();
    cand_idx = 3'd7;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("r1q0_drain_rm", rm_restart, (i == 3));
      chk("r1q0_drain_ready", cand_ready, 0);
      chk("r1q0_drain_csb1", leaf_mem_csb1, 1);
      chk("r1q0_drain_k0", k0_query_valid, 0);
      chk("r1q0_drain_s0v", s0_valid_in, 0);
      tick();
    end
    cand_valid = 1'b0;
    fsm_start = 1'b1;
    s0_ready = 1'b1;
    #1;
    chk("r1q0_s0v", s0_valid_in, 1);
    chk("r1q0_hand_row", row_idx, 1);
    chk("r1q0_hand_query", query_idx, 0);
    tick();
    fsm_start = 1'b0;
    s0_ready = 1'b0;

    // Row 1 query 1: back-to-back candidates 2, 3.
    cand_valid = 1'b1; cand_idx = 3'd2;
    #1;
    chk("r1q1_query", query_idx, 1);
    chk("r1q1_c2_addr1", leaf_mem_addr1, 2);
    chk("r1q1_c2_rm", rm_restart, 0);
    tick();
    cand_idx = 3'd3;
    #1;
    chk("r1q1_c3_addr1", leaf_mem_addr1, 3);
    chk("r1q1_c3_csb1", leaf_mem_csb1, 0);
    tick();
    cand_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("r1q1_drain_rm", rm_restart, (i == 4));
      chk("r1q1_drain_s0v", s0_valid_in, 0);
      tick();
    end
    s0_ready = 1'b1;
    fsm_start = 1'b1;
    #1;
    chk("r1q1_s0v", s0_valid_in, 1);
    chk("r1q1_busy", busy, 1);
    tick();
    s0_ready = 1'b0;
    chk("frame1_done", done, 1);
    chk("frame1_done_busy", busy, 0);
    chk("frame1_done_s0v", s0_valid_in, 0);
    chk("frame1_done_query", query_idx, 0);
    chk("frame1_done_row", row_idx, 0);
    tick();
    fsm_start = 1'b0;
    #1;
    chk("frame1_after_done", done, 0);
    chk("frame1_start_ignored", busy, 0);
    chk("frame1_after_csb0", leaf_mem_csb0, 1);

    // Exact-all frame: every row swept; mid-frame start and candidates ignored.
    fsm_start = 1'b1; mode_exact_all = 1'b1;
    tick();
    mode_exact_all = 1'b0;
    exact_query(0, 0, 0);
    fsm_start = 1'b0;
    cand_valid = 1'b1; cand_idx = 3'd4;
    exact_query(1, 0, 0);
    exact_query(0, 1, 1);
    exact_query(1, 1, 0);
    cand_valid = 1'b0;
    chk("frame2_done", done, 1);
    chk("frame2_done_busy", busy, 0);
    tick();
    chk("frame2_after_done", done, 0);
    chk("frame2_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
